uart_mem_bridge: RTL

- Byte-stream to block-RAM access bridge between the UART RX/TX byte links and a dual-port BRAM (port A write, port B read).
- Parametrised in address width, data word width, burst length and BRAM read latency.
- Adds burst writes with a write ACK, a NAK for bad opcodes, and an inter-byte timeout.
- A valid/ready TX handshake replaces level-enable transmission.

---
 rtl/uart_mem_pkg.sv | 24 ++
 rtl/uart_mem_bridge_tx_byte_shifter.sv | 64 ++++++
 rtl/uart_mem_bridge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg
// Shared definitions for the UART byte-stream to BRAM bridge: frame opcodes,
// default response bytes and the controller state encoding.
package uart_mem_pkg;

    localparam logic [7:0] OP_WRITE    = 8'h0F;
    localparam logic [7:0] OP_READ     = 8'hFF;
    localparam logic [7:0] ACK_DEFAULT = 8'hA5;
    localparam logic [7:0] NAK_DEFAULT = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_STRB,
        ST_WDATA,
        ST_ACK,
        ST_RFETCH,
        ST_RWAIT,
        ST_RSEND,
        ST_NAK
    } state_t;

endpackage

// File: rtl/uart_mem_bridge_tx_byte_shifter.sv
// tx_byte_shifter
// Holds one BRAM word and presents it on a valid/ready byte link, byte 0
// (bits [7:0]) first.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture load_word and start presenting it
//   load_word    : word to serialise
//   tx_ready     : downstream accepts the current byte this cycle
//   tx_valid     : a byte is being presented
//   tx_data      : current byte, stable until accepted
//   last_accept  : the final byte of the word is accepted this cycle
module tx_byte_shifter #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [8*DATA_BYTES-1:0] load_word,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    last_accept
);

    localparam int IDXW = $clog2(DATA_BYTES) + 1;

    logic [8*DATA_BYTES-1:0] word_q, word_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    valid_q, valid_d;

    assign last_accept = valid_q && tx_ready && (idx_q == IDXW'(DATA_BYTES - 1));
    assign tx_valid    = valid_q;
    assign tx_data     = word_q[7:0];

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            word_d  = load_word;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready) begin
            if (last_accept) begin
                valid_d = 1'b0;
            end else begin
                word_d = word_q >> 8;
                idx_d  = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
// Decodes write (0x0F) and read (0xFF) frames from a UART RX byte stream and
// drives a dual-port BRAM: port A for burst writes, port B for burst reads.
// Writes are acknowledged with ACK_BYTE, unknown opcodes answered with NAK_BYTE,
// and an idle gap of TIMEOUT_CYCLES during frame reception aborts the frame.
//   rx_valid/rx_data   : received byte strobe and value
//   tx_valid/tx_ready/tx_data : outgoing byte handshake
//   mem_addra/mem_wea/mem_dia : BRAM port A write
//   mem_addrb/mem_dob  : BRAM port B read
//   busy               : controller not idle
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 16,
    parameter int         DATA_BYTES     = 4,
    parameter int         RD_LATENCY     = 1,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic [ADDR_WIDTH-1:0]   mem_addra,
    output logic [DATA_BYTES-1:0]   mem_wea,
    output logic [8*DATA_BYTES-1:0] mem_dia,
    output logic [ADDR_WIDTH-1:0]   mem_addrb,
    input  logic [8*DATA_BYTES-1:0] mem_dob,
    output logic                    busy
);

    localparam int AB   = (ADDR_WIDTH + 7) / 8;
    localparam int IDXW = $clog2(DATA_BYTES) + 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(DATA_BYTES - 1));
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(DATA_BYTES);

    state_t                  state_q, state_d;
    logic                    is_read_q, is_read_d;
    logic [3:0]              abyte_q, abyte_d;
    logic [8*AB-1:0]         addr_sh_q, addr_sh_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [DATA_BYTES-1:0]   strb_q, strb_d;
    logic [7:0]              wcnt_q, wcnt_d;
    logic [IDXW-1:0]         bidx_q, bidx_d;
    logic [8*DATA_BYTES-1:0] wbuf_q, wbuf_d;
    logic [2:0]              lat_q, lat_d;
    logic [31:0]             to_cnt_q, to_cnt_d;
    logic                    ctrl_valid_q, ctrl_valid_d;
    logic [7:0]              ctrl_data_q, ctrl_data_d;
    logic [ADDR_WIDTH-1:0]   mem_addra_q, mem_addra_d;
    logic [DATA_BYTES-1:0]   mem_wea_q, mem_wea_d;
    logic [8*DATA_BYTES-1:0] mem_dia_q, mem_dia_d;
    logic [ADDR_WIDTH-1:0]   mem_addrb_q, mem_addrb_d;

    logic       rx_state;
    logic       sh_load, sh_valid, sh_last;
    logic [7:0] sh_data;

    tx_byte_shifter #(.DATA_BYTES(DATA_BYTES)) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (sh_load),
        .load_word  (mem_dob),
        .tx_ready   (tx_ready),
        .tx_valid   (sh_valid),
        .tx_data    (sh_data),
        .last_accept(sh_last)
    );

    // ACK/NAK and read data never overlap, so a simple OR/priority mux suffices.
    assign tx_valid  = ctrl_valid_q | sh_valid;
    assign tx_data   = sh_valid ? sh_data : ctrl_data_q;
    assign mem_addra = mem_addra_q;
    assign mem_wea   = mem_wea_q;
    assign mem_dia   = mem_dia_q;
    assign mem_addrb = mem_addrb_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        is_read_d    = is_read_q;
        abyte_d      = abyte_q;
        addr_sh_d    = addr_sh_q;
        addr_d       = addr_q;
        len_d        = len_q;
        strb_d       = strb_q;
        wcnt_d       = wcnt_q;
        bidx_d       = bidx_q;
        wbuf_d       = wbuf_q;
        lat_d        = lat_q;
        ctrl_valid_d = ctrl_valid_q;
        ctrl_data_d  = ctrl_data_q;
        mem_addra_d  = mem_addra_q;
        mem_wea_d    = '0;
        mem_dia_d    = mem_dia_q;
        mem_addrb_d  = mem_addrb_q;
        sh_load      = 1'b0;

        rx_state = (state_q inside {ST_ADDR, ST_LEN, ST_STRB, ST_WDATA});
        // Idle-gap counter only runs while a frame is being received.
        if (rx_state && !rx_valid) to_cnt_d = to_cnt_q + 32'd1;
        else                       to_cnt_d = '0;

        case (state_q)
            ST_IDLE: if (rx_valid) begin
                abyte_d   = '0;
                addr_sh_d = '0;
                wcnt_d    = '0;
                bidx_d    = '0;
                if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                    is_read_d = (rx_data == OP_READ);
                    state_d   = ST_ADDR;
                end else begin
                    ctrl_valid_d = 1'b1;
                    ctrl_data_d  = NAK_BYTE;
                    state_d      = ST_NAK;
                end
            end
            ST_ADDR: if (rx_valid) begin
                addr_sh_d[8*abyte_q +: 8] = rx_data;
                abyte_d = abyte_q + 4'd1;
                if (abyte_q == 4'(AB - 1)) begin
                    addr_d  = addr_sh_d[ADDR_WIDTH-1:0] & ALIGN_MASK;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: if (rx_valid) begin
                len_d = rx_data;
                if (is_read_q) begin
                    mem_addrb_d = addr_q;
                    state_d     = ST_RFETCH;
                end else begin
                    state_d = ST_STRB;
                end
            end
            ST_STRB: if (rx_valid) begin
                strb_d  = rx_data[DATA_BYTES-1:0];
                state_d = ST_WDATA;
            end
            ST_WDATA: if (rx_valid) begin
                wbuf_d[8*bidx_q +: 8] = rx_data;
                bidx_d = bidx_q + 1'b1;
                if (bidx_q == IDXW'(DATA_BYTES - 1)) begin
                    // Word complete: commit on the registered port-A outputs.
                    bidx_d      = '0;
                    mem_wea_d   = strb_q;
                    mem_addra_d = addr_q;
                    mem_dia_d   = wbuf_d;
                    addr_d      = addr_q + WORD_STEP;
                    if (wcnt_q == len_q) begin
                        ctrl_valid_d = 1'b1;
                        ctrl_data_d  = ACK_BYTE;
                        state_d      = ST_ACK;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            ST_ACK, ST_NAK: if (ctrl_valid_q && tx_ready) begin
                ctrl_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
            ST_RFETCH: begin
                lat_d   = '0;
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (lat_q == 3'(RD_LATENCY - 1)) begin
                    sh_load = 1'b1;
                    state_d = ST_RSEND;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_RSEND: if (sh_last) begin
                if (wcnt_q == len_q) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d      = wcnt_q + 8'd1;
                    addr_d      = addr_q + WORD_STEP;
                    mem_addrb_d = addr_q + WORD_STEP;
                    state_d     = ST_RFETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort an incomplete frame; already-committed words stay written.
        if (TO_EN && rx_state && !rx_valid && to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_read_q    <= 1'b0;
            abyte_q      <= '0;
            addr_sh_q    <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            strb_q       <= '0;
            wcnt_q       <= '0;
            bidx_q       <= '0;
            wbuf_q       <= '0;
            lat_q        <= '0;
            to_cnt_q     <= '0;
            ctrl_valid_q <= 1'b0;
            ctrl_data_q  <= '0;
            mem_addra_q  <= '0;
            mem_wea_q    <= '0;
            mem_dia_q    <= '0;
            mem_addrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            is_read_q    <= is_read_d;
            abyte_q      <= abyte_d;
            addr_sh_q    <= addr_sh_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            strb_q       <= strb_d;
            wcnt_q       <= wcnt_d;
            bidx_q       <= bidx_d;
            wbuf_q       <= wbuf_d;
            lat_q        <= lat_d;
            to_cnt_q     <= to_cnt_d;
            ctrl_valid_q <= ctrl_valid_d;
            ctrl_data_q  <= ctrl_data_d;
            mem_addra_q  <= mem_addra_d;
            mem_wea_q    <= mem_wea_d;
            mem_dia_q    <= mem_dia_d;
            mem_addrb_q  <= mem_addrb_d;
        end
    end

endmodule
